// File: rtl/mem_cache_stage.sv
// MEM stage: 2-way set-associative write-through cache over a handshaked SRAM port, plus the MEM/WB register.
// Define MEM_CACHE_STATS_EN to add the hit_count/miss_count load statistics ports.
module mem_cache_stage #(
   parameter int BASE_ADDR = 1024,
   parameter int SETS      = 64,
   parameter int TAG_W     = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_res_MEM,
   input  logic [31:0] rm_val_MEM,
   input  logic [3:0]  dest_MEM,
   input  logic        WB_EN_MEM,
   input  logic        MEM_R_EN_MEM,
   input  logic        MEM_W_EN_MEM,
   output logic        freeze,
   output logic [31:0] alu_res_WB,
   output logic [31:0] mem_data_WB,
   output logic [3:0]  dest_WB,
   output logic        WB_EN_WB,
   output logic        MEM_R_EN_WB,
   output logic        sram_req,
   output logic        sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ack
`ifdef MEM_CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR, DONE} state_t;

   state_t state;

   logic [31:0]      ea;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             word_sel;
   logic [31:0]      line_addr;
   logic [31:0]      word_addr;

   logic             valid_q [2][SETS];
   logic [TAG_W-1:0] tag_q   [2][SETS];
   logic [63:0]      data_q  [2][SETS];
   logic             lru_q   [SETS];

   logic        is_load, is_store;
   logic        hit0, hit1, hit, hit_way, fill_way;
   logic [63:0] hit_line;
   logic [31:0] hit_word;
   logic [31:0] load_word;
   logic [63:0] line_buf;

   assign ea        = alu_res_MEM - 32'(BASE_ADDR);
   assign idx       = ea[IDX_W+2:3];
   assign tag       = ea[TAG_W+IDX_W+2:IDX_W+3];
   assign word_sel  = ea[2];
   assign line_addr = (ea & ~32'h7) + 32'(BASE_ADDR);
   assign word_addr = (ea & ~32'h3) + 32'(BASE_ADDR);

   // A simultaneous read/write request is treated as a store.
   assign is_store = MEM_W_EN_MEM;
   assign is_load  = MEM_R_EN_MEM & ~MEM_W_EN_MEM;

   assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
   assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
   assign hit      = hit0 | hit1;
   assign hit_way  = hit1;
   assign hit_line = hit_way ? data_q[1][idx] : data_q[0][idx];
   assign hit_word = word_sel ? hit_line[63:32] : hit_line[31:0];

   // Prefer an empty way; LRU only matters once both ways hold lines.
   assign fill_way = !valid_q[0][idx] ? 1'b0 :
                     !valid_q[1][idx] ? 1'b1 : lru_q[idx];

   assign load_word = (state == DONE) ? (word_sel ? line_buf[63:32] : line_buf[31:0]) : hit_word;

   always_comb begin
      freeze = 1'b0;
      case (state)
         IDLE:         freeze = is_store | (is_load & ~hit);
         RD0, RD1, WR: freeze = 1'b1;
         default:      freeze = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sram_req   <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         line_buf   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (is_store) begin
                  state      <= WR;
                  sram_req   <= 1'b1;
                  sram_we    <= 1'b1;
                  sram_addr  <= word_addr;
                  sram_wdata <= rm_val_MEM;
               end else if (is_load && !hit) begin
                  state     <= RD0;
                  sram_req  <= 1'b1;
                  sram_we   <= 1'b0;
                  sram_addr <= line_addr;
               end
            end
            RD0: begin
               if (sram_ack) begin
                  line_buf[31:0] <= sram_rdata;
                  sram_addr      <= line_addr + 32'd4;
                  state          <= RD1;
               end
            end
            RD1: begin
               if (sram_ack) begin
                  line_buf[63:32] <= sram_rdata;
                  sram_req        <= 1'b0;
                  state           <= DONE;
               end
            end
            WR: begin
               if (sram_ack) begin
                  sram_req <= 1'b0;
                  sram_we  <= 1'b0;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data arrays need no reset; only valid and LRU bits are cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '{default: 1'b0};
         lru_q   <= '{default: 1'b0};
      end else begin
         if (state == IDLE && hit && (is_load || is_store)) begin
            lru_q[idx] <= ~hit_way;
            if (is_store) begin
               if (word_sel) data_q[hit_way][idx][63:32] <= rm_val_MEM;
               else          data_q[hit_way][idx][31:0]  <= rm_val_MEM;
            end
         end
         if (state == RD1 && sram_ack) begin
            valid_q[fill_way][idx] <= 1'b1;
            tag_q[fill_way][idx]   <= tag;
            data_q[fill_way][idx]  <= {sram_rdata, line_buf[31:0]};
            lru_q[idx]             <= ~fill_way;
         end
      end
   end

`ifdef MEM_CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == IDLE && is_load) begin
         if (hit) hit_count  <= hit_count + 32'd1;
         else     miss_count <= miss_count + 32'd1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_res_WB  <= '0;
         mem_data_WB <= '0;
         dest_WB     <= '0;
         WB_EN_WB    <= 1'b0;
         MEM_R_EN_WB <= 1'b0;
      end else if (!freeze) begin
         alu_res_WB  <= alu_res_MEM;
         mem_data_WB <= load_word;
         dest_WB     <= dest_MEM;
         WB_EN_WB    <= WB_EN_MEM;
         MEM_R_EN_WB <= MEM_R_EN_MEM;
      end
   end

endmodule

// File: tb/tb_mem_cache_stage.sv
// Bench for mem_cache_stage: directed scenarios plus randomized ops against a line-level LRU/memory model.
`timescale 1ns/1ps
module tb_mem_cache_stage;

   localparam int SETS = 64;
   localparam int BASE = 1024;

   logic        clk;
   logic        rst;
   logic [31:0] alu_res_MEM, rm_val_MEM;
   logic [3:0]  dest_MEM;
   logic        WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
   logic        freeze;
   logic [31:0] alu_res_WB, mem_data_WB;
   logic [3:0]  dest_WB;
   logic        WB_EN_WB, MEM_R_EN_WB;
   logic        sram_req, sram_we;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;
   logic        sram_ack;
`ifdef MEM_CACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   mem_cache_stage dut (
      .clk(clk), .rst(rst),
      .alu_res_MEM(alu_res_MEM), .rm_val_MEM(rm_val_MEM), .dest_MEM(dest_MEM),
      .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
      .freeze(freeze),
      .alu_res_WB(alu_res_WB), .mem_data_WB(mem_data_WB), .dest_WB(dest_WB),
      .WB_EN_WB(WB_EN_WB), .MEM_R_EN_WB(MEM_R_EN_WB),
      .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
`ifdef MEM_CACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xact_t;

   int vectors = 0;
   int miscompares = 0;
   int wait_n = 2;
   bit manual_sram = 0;
   int model_hits = 0;
   int model_misses = 0;
   logic [31:0] sram_mem [int unsigned];
   logic [31:0] ref_mem  [int unsigned];
   xact_t       sram_log [$];
   int unsigned mru [$];

   function automatic logic [31:0] init_word(int unsigned w);
      return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] sram_read(int unsigned w);
      if (!sram_mem.exists(w)) sram_mem[w] = init_word(w);
      return sram_mem[w];
   endfunction

   function automatic logic [31:0] ref_read(int unsigned w);
      if (!ref_mem.exists(w)) ref_mem[w] = init_word(w);
      return ref_mem[w];
   endfunction

   // Resident lines kept most-recently-used first; two lines per set at most.
   function automatic bit model_access(int unsigned line, bit allocate);
      int found[$];
      int same;
      int victim;
      found = mru.find_first_index(x) with (x == line);
      if (found.size() != 0) begin
         mru.delete(found[0]);
         mru.push_front(line);
         return 1'b1;
      end
      if (allocate) begin
         same = 0;
         victim = -1;
         foreach (mru[i]) if (mru[i] % SETS == line % SETS) begin same++; victim = i; end
         if (same >= 2) mru.delete(victim);
         mru.push_front(line);
      end
      return 1'b0;
   endfunction

   // SRAM responder: acks after wait_n idle cycles of a held request.
   initial begin
      int cnt;
      xact_t x;
      cnt = 0;
      sram_ack = 1'b0;
      sram_rdata = '0;
      forever begin
         @(negedge clk);
         if (manual_sram) cnt = 0;
         else if (rst) begin sram_ack = 1'b0; cnt = 0; end
         else begin
            if (sram_ack) begin sram_ack = 1'b0; cnt = 0; end
            if (sram_req) begin
               cnt++;
               if (cnt > wait_n) begin
                  sram_ack = 1'b1;
                  if (sram_we) sram_mem[sram_addr >> 2] = sram_wdata;
                  else sram_rdata = sram_read(sram_addr >> 2);
                  x.we = sram_we; x.addr = sram_addr; x.wdata = sram_wdata;
                  sram_log.push_back(x);
               end
            end else cnt = 0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      MEM_R_EN_MEM = 1'b0; MEM_W_EN_MEM = 1'b0; WB_EN_MEM = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mru.delete();
      model_hits = 0;
      model_misses = 0;
   endtask

   task automatic run_op(input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst,
                         input logic wb, input logic rd, input logic wr,
                         output int frz);
      @(negedge clk);
      alu_res_MEM = alu; rm_val_MEM = rm; dest_MEM = dst;
      WB_EN_MEM = wb; MEM_R_EN_MEM = rd; MEM_W_EN_MEM = wr;
      sram_log.delete();
      frz = 0;
      #1;
      while (freeze !== 1'b0 && frz <= 100) begin
         frz++;
         @(negedge clk); #1;
      end
      if (frz > 100) begin
         vectors++; miscompares++;
         $display("[TB] FAIL op_timeout: freeze stuck for %0d cycles, required release", frz);
      end
      @(posedge clk); #1;
      MEM_R_EN_MEM = 1'b0; MEM_W_EN_MEM = 1'b0; WB_EN_MEM = 1'b0;
   endtask

   task automatic test_reset();
      int frz;
      run_op(32'h1234, 32'h0, 4'd7, 1'b1, 1'b0, 1'b0, frz);
      do_reset();
      #1;
      vectors++; if (sram_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %b expected 0", sram_req); end
      vectors++; if (sram_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we: got %b expected 0", sram_we); end
      vectors++; if (freeze !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_freeze: got %b expected 0", freeze); end
      vectors++; if (alu_res_WB !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_alu_wb: got %h expected 0", alu_res_WB); end
      vectors++; if (dest_WB !== 4'h0 || WB_EN_WB !== 1'b0 || MEM_R_EN_WB !== 1'b0 || mem_data_WB !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL rst_wb_regs: got dest=%h wb=%b rd=%b data=%h expected all 0", dest_WB, WB_EN_WB, MEM_R_EN_WB, mem_data_WB);
      end
   endtask

   task automatic test_non_mem();
      int frz;
      do_reset();
      run_op(32'h55, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, frz);
      vectors++; if (frz != 0) begin miscompares++; $display("[TB] FAIL nonmem_freeze: got %0d cycles expected 0", frz); end
      vectors++; if (alu_res_WB !== 32'h55) begin miscompares++; $display("[TB] FAIL nonmem_alu: got %h expected 55", alu_res_WB); end
      vectors++; if (dest_WB !== 4'd3 || WB_EN_WB !== 1'b1 || MEM_R_EN_WB !== 1'b0) begin
         miscompares++; $display("[TB] FAIL nonmem_ctrl: got dest=%0d wb=%b rd=%b expected 3 1 0", dest_WB, WB_EN_WB, MEM_R_EN_WB);
      end
   endtask

   task automatic test_cold_fill();
      int frz;
      do_reset();
      wait_n = 2;
      sram_mem[256] = 32'hA0; ref_mem[256] = 32'hA0;
      sram_mem[257] = 32'hA1; ref_mem[257] = 32'hA1;
      run_op(32'd1024, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, frz);
      vectors++; if (frz != 7) begin miscompares++; $display("[TB] FAIL cold_freeze: got %0d cycles expected 7", frz); end
      vectors++;
      if (sram_log.size() != 2) begin miscompares++; $display("[TB] FAIL cold_xacts: got %0d expected 2", sram_log.size()); end
      else if (sram_log[0].addr !== 32'd1024 || sram_log[1].addr !== 32'd1028 || sram_log[0].we || sram_log[1].we) begin
         miscompares++; $display("[TB] FAIL cold_addr: got %0d,%0d expected 1024,1028 reads", sram_log[0].addr, sram_log[1].addr);
      end
      vectors++; if (mem_data_WB !== 32'hA0 || MEM_R_EN_WB !== 1'b1) begin
         miscompares++; $display("[TB] FAIL cold_data: got %h expected a0", mem_data_WB);
      end
      run_op(32'd1028, 32'h0, 4'd2, 1'b1, 1'b1, 1'b0, frz);
      vectors++; if (frz != 0 || sram_log.size() != 0) begin
         miscompares++; $display("[TB] FAIL hit_nostall: got freeze=%0d xacts=%0d expected 0 0", frz, sram_log.size());
      end
      vectors++; if (mem_data_WB !== 32'hA1) begin miscompares++; $display("[TB] FAIL hit_data: got %h expected a1", mem_data_WB); end
`ifdef MEM_CACHE_STATS_EN
      vectors++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
         miscompares++; $display("[TB] FAIL stats_cold: got hit=%0d miss=%0d expected 1 1", hit_count, miss_count);
      end
`endif
   endtask

   task automatic test_store_hit();
      int frz;
      do_reset();
      wait_n = 2;
      run_op(32'd1024, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, frz);
      run_op(32'd1028, 32'hDEAD, 4'd0, 1'b0, 1'b0, 1'b1, frz);
      ref_mem[257] = 32'hDEAD;
      vectors++; if (frz != 4) begin miscompares++; $display("[TB] FAIL store_freeze: got %0d cycles expected 4", frz); end
      vectors++;
      if (sram_log.size() != 1) begin miscompares++; $display("[TB] FAIL store_xacts: got %0d expected 1", sram_log.size()); end
      else if (!sram_log[0].we || sram_log[0].addr !== 32'd1028 || sram_log[0].wdata !== 32'hDEAD) begin
         miscompares++; $display("[TB] FAIL store_write: got we=%b addr=%0d data=%h expected 1 1028 dead",
                                 sram_log[0].we, sram_log[0].addr, sram_log[0].wdata);
      end
      run_op(32'd1028, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, frz);
      vectors++; if (frz != 0 || sram_log.size() != 0) begin
         miscompares++; $display("[TB] FAIL store_hit_stall: got freeze=%0d xacts=%0d expected 0 0", frz, sram_log.size());
      end
      vectors++; if (mem_data_WB !== 32'hDEAD) begin miscompares++; $display("[TB] FAIL store_hit_data: got %h expected dead", mem_data_WB); end
   endtask

   task automatic test_evict();
      int frz;
      logic [31:0] seq [5] = '{32'd1024, 32'd5120, 32'd1024, 32'd9216, 32'd5120};
      bit          exp_hit [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] exp;
      do_reset();
      wait_n = 1;
      for (int i = 0; i < 5; i++) begin
         exp = ref_read(seq[i] >> 2);
         run_op(seq[i], 32'h0, 4'(i), 1'b1, 1'b1, 1'b0, frz);
         vectors++; if ((frz == 0) != exp_hit[i] || (exp_hit[i] ? 0 : 5) != frz) begin
            miscompares++; $display("[TB] FAIL evict_step%0d: got freeze=%0d expected %0d", i, frz, exp_hit[i] ? 0 : 5);
         end
         vectors++; if (mem_data_WB !== exp) begin
            miscompares++; $display("[TB] FAIL evict_data%0d: got %h expected %h", i, mem_data_WB, exp);
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      int k;
      logic [31:0] exp;
      do_reset();
      manual_sram = 1'b1;
      @(negedge clk);
      alu_res_MEM = 32'd1024; dest_MEM = 4'd2; WB_EN_MEM = 1'b1; MEM_R_EN_MEM = 1'b1; MEM_W_EN_MEM = 1'b0;
      k = 0;
      while (sram_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      vectors++; if (sram_req !== 1'b1 || sram_addr !== 32'd1024) begin
         miscompares++; $display("[TB] FAIL mid_rd0: got req=%b addr=%0d expected 1 1024", sram_req, sram_addr);
      end
      sram_rdata = 32'h1111; sram_ack = 1'b1;
      @(negedge clk);
      sram_ack = 1'b0;
      vectors++; if (sram_req !== 1'b1 || sram_addr !== 32'd1028) begin
         miscompares++; $display("[TB] FAIL mid_rd1: got req=%b addr=%0d expected 1 1028", sram_req, sram_addr);
      end
      rst = 1'b1; sram_ack = 1'b1; sram_rdata = 32'h2222;
      @(posedge clk); #1;
      vectors++; if (sram_req !== 1'b0 || sram_we !== 1'b0 || WB_EN_WB !== 1'b0) begin
         miscompares++; $display("[TB] FAIL mid_rst: got req=%b we=%b wb=%b expected 0 0 0", sram_req, sram_we, WB_EN_WB);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      vectors++; if (sram_req !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 32'd1024) begin
         miscompares++; $display("[TB] FAIL mid_remiss: got req=%b we=%b addr=%0d expected 1 0 1024", sram_req, sram_we, sram_addr);
      end
      @(negedge clk);
      sram_ack = 1'b0;
      wait_n = 1;
      manual_sram = 1'b0;
      mru.delete();
      exp = ref_read(256);
      k = 0;
      #1;
      while (freeze !== 1'b0 && k < 100) begin @(negedge clk); #1; k++; end
      vectors++; if (k >= 100) begin miscompares++; $display("[TB] FAIL mid_timeout: got %0d cycles expected release", k); end
      @(posedge clk); #1;
      MEM_R_EN_MEM = 1'b0; WB_EN_MEM = 1'b0;
      vectors++; if (mem_data_WB !== exp || MEM_R_EN_WB !== 1'b1) begin
         miscompares++; $display("[TB] FAIL mid_data: got %h expected %h", mem_data_WB, exp);
      end
   endtask

   task automatic test_random_ops();
      int frz, exp_frz, exp_log, kind;
      logic [31:0] ea, alu, rm, exp_data;
      logic [3:0] dst;
      logic rd, wr, wb, hit;
      int unsigned waddr, line;
      do_reset();
      for (int n = 0; n < 200; n++) begin
         kind = int'($urandom_range(0, 9));
         ea = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3) |
              (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
         alu = ea + BASE;
         rm = $urandom;
         dst = 4'($urandom_range(0, 15));
         wait_n = int'($urandom_range(0, 3));
         rd = (kind < 4);
         wr = (kind >= 4 && kind < 7);
         wb = rd | 1'($urandom_range(0, 1));
         waddr = ((ea & ~32'h3) + BASE) >> 2;
         line = ea >> 3;
         exp_frz = 0; exp_log = 0; exp_data = '0; hit = 1'b0;
         if (rd) begin
            hit = model_access(line, 1'b1);
            exp_data = ref_read(waddr);
            if (hit) model_hits++; else model_misses++;
            exp_frz = hit ? 0 : 2 * wait_n + 3;
            exp_log = hit ? 0 : 2;
         end else if (wr) begin
            hit = model_access(line, 1'b0);
            ref_mem[waddr] = rm;
            exp_frz = wait_n + 2;
            exp_log = 1;
         end
         run_op(alu, rm, dst, wb, rd, wr, frz);
         vectors++; if (frz != exp_frz) begin
            miscompares++; $display("[TB] FAIL rnd%0d_freeze: got %0d expected %0d (rd=%b wr=%b ea=%h)", n, frz, exp_frz, rd, wr, ea);
         end
         vectors++;
         if (sram_log.size() != exp_log) begin
            miscompares++; $display("[TB] FAIL rnd%0d_xacts: got %0d expected %0d", n, sram_log.size(), exp_log);
         end else if (exp_log == 2 && (sram_log[0].addr !== ((ea & ~32'h7) + BASE) || sram_log[1].addr !== ((ea & ~32'h7) + BASE + 4))) begin
            miscompares++; $display("[TB] FAIL rnd%0d_rdaddr: got %h,%h expected line of ea %h", n, sram_log[0].addr, sram_log[1].addr, ea);
         end else if (exp_log == 1 && (!sram_log[0].we || sram_log[0].addr !== (waddr << 2) || sram_log[0].wdata !== rm)) begin
            miscompares++; $display("[TB] FAIL rnd%0d_write: got addr=%h data=%h expected %h %h", n, sram_log[0].addr, sram_log[0].wdata, waddr << 2, rm);
         end
         vectors++; if (alu_res_WB !== alu || dest_WB !== dst || WB_EN_WB !== wb || MEM_R_EN_WB !== rd) begin
            miscompares++; $display("[TB] FAIL rnd%0d_wbregs: got alu=%h dest=%0d wb=%b rd=%b expected %h %0d %b %b",
                                    n, alu_res_WB, dest_WB, WB_EN_WB, MEM_R_EN_WB, alu, dst, wb, rd);
         end
         if (rd) begin
            vectors++; if (mem_data_WB !== exp_data) begin
               miscompares++; $display("[TB] FAIL rnd%0d_load: got %h expected %h (hit=%b)", n, mem_data_WB, exp_data, hit);
            end
         end
      end
`ifdef MEM_CACHE_STATS_EN
      vectors++; if (hit_count !== 32'(model_hits) || miss_count !== 32'(model_misses)) begin
         miscompares++; $display("[TB] FAIL stats_rnd: got hit=%0d miss=%0d expected %0d %0d", hit_count, miss_count, model_hits, model_misses);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      alu_res_MEM = '0; rm_val_MEM = '0; dest_MEM = '0;
      WB_EN_MEM = 1'b0; MEM_R_EN_MEM = 1'b0; MEM_W_EN_MEM = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_non_mem();
      test_cold_fill();
      test_store_hit();
      test_evict();
      test_reset_mid_fill();
      test_random_ops();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
